// File: rtl/apb3_master.sv
`default_nettype none
// ============================================================================
// apb3_master : APB3 initiator bridging a valid/ready command stream to
//               SETUP/ACCESS transfers and returning a valid/ready response.
//               Optional ACCESS timeout enabled by APB3_MASTER_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module apb3_master #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  io_systemClk,
  input  logic                  io_systemReset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic                  PREADY,
  input  logic [31:0]           PRDATA,
  input  logic                  PSLVERROR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       w_cmd_fire;
  logic       w_timeout_hit;
  logic       w_access_done;
  logic [1:0] w_unused_addr_lsb;

  // Byte lanes below word granularity never reach the bus.
  assign w_unused_addr_lsb = cmd_addr[1:0];

`ifdef APB3_MASTER_TIMEOUT_EN
  localparam int unsigned C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LIMIT = C_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [C_CNT_W-1:0] r_to_cnt;

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_ACCESS && !PREADY) begin
      r_to_cnt <= r_to_cnt + C_CNT_W'(1);
    end
  end

  assign w_timeout_hit = (r_state == ST_ACCESS) && !PREADY && (r_to_cnt == C_CNT_LIMIT);
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout_hit    = 1'b0;
`endif

  assign w_access_done = (r_state == ST_ACCESS) && (PREADY || w_timeout_hit);

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_cmd_fire)    w_state_nxt = ST_SETUP;
      ST_SETUP:                     w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_access_done) w_state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready)     w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (r_state == ST_IDLE) && !io_systemReset;
    busy       = (r_state != ST_IDLE);
    w_cmd_fire = cmd_valid && cmd_ready;
  end

  // PSEL/PENABLE follow the next state so they are aligned with the state register.
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        PADDR  <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
        PWRITE <= cmd_write;
        PWDATA <= cmd_wdata;
      end
      PSEL    <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
      PENABLE <= (w_state_nxt == ST_ACCESS);
      if (w_access_done) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : 32'h0;
        rsp_error <= PREADY ? PSLVERROR : 1'b1;
      end else if (r_state == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb3_master.sv
`default_nettype none
// Self-checking bench for apb3_master: scripted APB responder plus response scoreboard.
module tb_apb3_master;

  localparam int AW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_error, busy;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERROR;
  logic [31:0]   PWDATA, PRDATA;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb3_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .io_systemClk(clk), .io_systemReset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERROR(PSLVERROR)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and wait (bounded) for acceptance; returns the accept cycle.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                       output int t, output bit ok);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    ok = 1'b0; t = -1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        t = cyc; ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; PREADY = 1'b0; PRDATA = '0; PSLVERROR = 1'b0;
    repeat (3) tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_error, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h rsp_valid=%b rsp_rdata=%h rsp_error=%b busy=%b, required all 0",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_error, busy);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL post_reset_cmd_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_write();
    int t; bit ok; logic [32:0] e;
    PREADY = 1'b1; PSLVERROR = 1'b0; PRDATA = 32'hDEADBEEF; rsp_ready = 1'b1;
    issue(1'b1, 16'h0010, 32'h12345678, t, ok);
    exp_q.push_back({1'b0, 32'h0});
    checks++;
    if (!ok) begin fails++; $display("FAIL write_accept: got no accept required accept"); end
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 16'h0010, 32'h12345678}) begin
      fails++;
      $display("FAIL write_setup: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h required 1 0 1 0010 12345678",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    tick();
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin fails++; $display("FAIL write_access: PSEL/PENABLE=%b required 11", {PSEL, PENABLE}); end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || cyc != t + 3) begin
      fails++; $display("FAIL write_rsp_latency: rsp_valid=%b at cycle offset %0d required 1 at 3", rsp_valid, cyc - t);
    end
    e = exp_q.pop_front();
    checks++;
    if ({rsp_error, rsp_rdata} !== e || {PSEL, PENABLE} !== 2'b00) begin
      fails++; $display("FAIL write_rsp: err/rdata=%h psel/penable=%b required %h 00", {rsp_error, rsp_rdata}, {PSEL, PENABLE}, e);
    end
    tick();
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      fails++; $display("FAIL write_return_idle: rsp_valid/cmd_ready/busy=%b required 010", {rsp_valid, cmd_ready, busy});
    end
  endtask

  task automatic test_wait_read();
    int t; bit ok; int en_cnt; logic [32:0] e;
    PREADY = 1'b0; PRDATA = 32'h11111111; rsp_ready = 1'b1;
    issue(1'b0, 16'h0023, 32'hFFFF0000, t, ok);
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    checks++;
    if (!ok || PADDR !== 16'h0020 || PWRITE !== 1'b0) begin
      fails++; $display("FAIL read_setup: ok=%b PADDR=%h PWRITE=%b required 1 0020 0", ok, PADDR, PWRITE);
    end
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (PENABLE === 1'b1 && PSEL === 1'b1 && PADDR === 16'h0020) en_cnt++;
      if (i == 3) begin PREADY = 1'b1; PRDATA = 32'hA5A5A5A5; end
    end
    tick();
    PREADY = 1'b0; PRDATA = 32'h22222222;
    checks++;
    if (en_cnt != 4) begin fails++; $display("FAIL read_access_cycles: got %0d stable ACCESS cycles required 4", en_cnt); end
    checks++;
    if (rsp_valid !== 1'b1 || cyc != t + 6) begin
      fails++; $display("FAIL read_rsp_latency: rsp_valid=%b offset %0d required 1 at 6", rsp_valid, cyc - t);
    end
    e = exp_q.pop_front();
    checks++;
    if ({rsp_error, rsp_rdata} !== e) begin fails++; $display("FAIL read_rsp_data: got %h required %h", {rsp_error, rsp_rdata}, e); end
    tick();
  endtask

  task automatic test_slverr();
    int t; bit ok; logic [32:0] e;
    PREADY = 1'b1; PSLVERROR = 1'b1; PRDATA = 32'h00000BAD; rsp_ready = 1'b1;
    issue(1'b0, 16'h0104, 32'h0, t, ok);
    exp_q.push_back({1'b1, 32'h00000BAD});
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    checks++;
    if (!ok || rsp_valid !== 1'b1) begin fails++; $display("FAIL slverr_timeout: ok=%b rsp_valid=%b required 1 1", ok, rsp_valid); end
    e = exp_q.pop_front();
    checks++;
    if ({rsp_error, rsp_rdata} !== e) begin fails++; $display("FAIL slverr_rsp: got %h required %h", {rsp_error, rsp_rdata}, e); end
    PSLVERROR = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int t; bit ok; int held; logic [32:0] e;
    PREADY = 1'b1; PRDATA = 32'h0C0FFEE0; rsp_ready = 1'b0;
    issue(1'b0, 16'h0040, 32'h0, t, ok);
    exp_q.push_back({1'b0, 32'h0C0FFEE0});
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    PRDATA = 32'h55555555;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0080; cmd_wdata = 32'hCAFEF00D;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid === 1'b1 && rsp_rdata === 32'h0C0FFEE0 && cmd_ready === 1'b0 && PSEL === 1'b0) held++;
      tick();
    end
    checks++;
    if (held != 5) begin fails++; $display("FAIL bp_hold: got %0d held cycles required 5", held); end
    e = exp_q.pop_front();
    checks++;
    if ({rsp_error, rsp_rdata} !== e) begin fails++; $display("FAIL bp_rsp: got %h required %h", {rsp_error, rsp_rdata}, e); end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_next_accept: rsp_valid/cmd_ready=%b required 01", {rsp_valid, cmd_ready});
    end
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back({1'b0, 32'h0});
    checks++;
    if ({PSEL, PADDR, PWDATA} !== {1'b1, 16'h0080, 32'hCAFEF00D}) begin
      fails++; $display("FAIL bp_second_setup: PSEL=%b PADDR=%h PWDATA=%h required 1 0080 cafef00d", PSEL, PADDR, PWDATA);
    end
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    e = exp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || {rsp_error, rsp_rdata} !== e) begin
      fails++; $display("FAIL bp_second_rsp: valid=%b data=%h required 1 %h", rsp_valid, {rsp_error, rsp_rdata}, e);
    end
    tick();
  endtask

  task automatic test_timeout();
    int t; bit ok; int en_cnt; logic [32:0] e;
    PREADY = 1'b0; PRDATA = 32'h77777777; rsp_ready = 1'b1;
    issue(1'b0, 16'h0200, 32'h0, t, ok);
    en_cnt = 0;
`ifdef APB3_MASTER_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'h0});
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      tick();
      if (PENABLE === 1'b1) en_cnt++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || cyc != t + 18 || en_cnt != TO) begin
      fails++; $display("FAIL timeout_abort: rsp_valid=%b offset %0d access=%0d required 1 18 %0d", rsp_valid, cyc - t, en_cnt, TO);
    end
    e = exp_q.pop_front();
    checks++;
    if ({rsp_error, rsp_rdata} !== e) begin fails++; $display("FAIL timeout_rsp: got %h required %h", {rsp_error, rsp_rdata}, e); end
    tick();
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      if (PENABLE === 1'b1 && rsp_valid === 1'b0) en_cnt++;
    end
    checks++;
    if (!ok || en_cnt != 40) begin fails++; $display("FAIL no_timeout_wait: got %0d ACCESS cycles required 40", en_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    int t; bit ok; int quiet;
    PREADY = 1'b0; rsp_ready = 1'b1;
    issue(1'b0, 16'h0300, 32'h0, t, ok);
    tick();
    checks++;
    if (!ok || PENABLE !== 1'b1) begin fails++; $display("FAIL rmid_access: ok=%b PENABLE=%b required 1 1", ok, PENABLE); end
    rst = 1'b1;
    tick();
    checks++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready, busy} !== 5'b0) begin
      fails++; $display("FAIL rmid_abort: PSEL/PENABLE/rsp_valid/cmd_ready/busy=%b required 00000", {PSEL, PENABLE, rsp_valid, cmd_ready, busy});
    end
    rst = 1'b0;
    PREADY = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rmid_cmd_ready: got %b required 1", cmd_ready); end
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid === 1'b0 && PSEL === 1'b0) quiet++;
    end
    checks++;
    if (quiet != 5) begin fails++; $display("FAIL rmid_no_rsp: got %0d quiet cycles required 5", quiet); end
  endtask

  task automatic test_back_to_back();
    int t; bit ok; int waits; int stall; logic w; logic [AW-1:0] a; logic [31:0] d, rd; logic err;
    logic [32:0] e;
    for (int n = 0; n < 8; n++) begin
      w = 1'($urandom_range(0, 1)); a = AW'($urandom); d = $urandom; rd = $urandom;
      err = ($urandom_range(0, 3) == 0); waits = $urandom_range(0, 2); stall = $urandom_range(0, 2);
      PREADY = 1'b0; rsp_ready = 1'b0;
      issue(w, a, d, t, ok);
      tick();
      for (int i = 0; i < waits; i++) tick();
      checks++;
      if (!ok || PENABLE !== 1'b1 || PADDR !== {a[AW-1:2], 2'b00} || PWRITE !== w || PWDATA !== d) begin
        fails++; $display("FAIL b2b_access[%0d]: PENABLE=%b PADDR=%h PWRITE=%b PWDATA=%h required 1 %h %b %h",
                          n, PENABLE, PADDR, PWRITE, PWDATA, {a[AW-1:2], 2'b00}, w, d);
      end
      PREADY = 1'b1; PRDATA = rd; PSLVERROR = err;
      exp_q.push_back({err, w ? 32'h0 : rd});
      tick();
      PREADY = 1'b0; PSLVERROR = 1'b0;
      for (int i = 0; i < stall; i++) tick();
      rsp_ready = 1'b1;
      e = exp_q.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_error, rsp_rdata} !== e) begin
        fails++; $display("FAIL b2b_rsp[%0d]: valid=%b data=%h required 1 %h", n, rsp_valid, {rsp_error, rsp_rdata}, e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_read();
    test_slverr();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
